// File: rtl/giraffe_pkg.sv
// rtl/giraffe_pkg.sv - shared types and constants for the Giraffe ADC emulator
//
// Contents:
//   emu_state_t   emulator FSM states (IDLE, LAT, SUB, GAP, REST)
//   DEF_*         default sizing and latency constants
//   LFSR_SEED     reseed value of the optional data LFSR
//   LFSR_TAPS     feedback mask for x^16+x^14+x^13+x^11+1 in right-shift form

package giraffe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAT,
    ST_SUB,
    ST_GAP,
    ST_REST
  } emu_state_t;

  localparam int DEF_NUM_BIT   = 6;
  localparam int DEF_NUM_STAGE = 2;
  localparam int DEF_CONV_LAT  = 4;
  localparam int DEF_SUB_GAP   = 2;
  localparam int DEF_FRAME_GAP = 3;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Shift right, feed back into bit 15; tap x^t sits at bit 16-t (bits 0,2,3,5).
  localparam logic [15:0] LFSR_TAPS = 16'h002D;

endpackage

// File: rtl/giraffe_emu_datagen.sv
// rtl/giraffe_emu_datagen.sv - normal-mode sub-word source (ramp or LFSR)
//
// Optional build macro: GIRAFFE_EMU_LFSR_EN selects the 16-bit LFSR source;
// otherwise a NUM_bit ramp is used.
//
// Ports:
//   clk      in   clock
//   nrst     in   asynchronous active-low reset (reseeds the source)
//   clear    in   synchronous reseed/clear, has priority over advance
//   advance  in   step the source once; data is the word emitted for that step
//   data     out  NUM_bit word to emit on the current sub-word

module giraffe_emu_datagen
  import giraffe_pkg::*;
#(
  parameter int NUM_bit = DEF_NUM_BIT
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               clear,
  input  logic               advance,
  output logic [NUM_bit-1:0] data
);

`ifdef GIRAFFE_EMU_LFSR_EN
  logic [15:0] lfsr;
  logic [15:0] lfsr_next;

  assign lfsr_next = {^(lfsr & LFSR_TAPS), lfsr[15:1]};
  // The first emitted word is the state after one step from the seed.
  assign data = lfsr_next[NUM_bit-1:0];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lfsr <= LFSR_SEED;
    end else if (clear) begin
      lfsr <= LFSR_SEED;
    end else if (advance) begin
      lfsr <= lfsr_next;
    end
  end
`else
  logic [NUM_bit-1:0] ramp;

  // The ramp emits its current value, then moves on; wrap is natural overflow.
  assign data = ramp;

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      ramp <= '0;
    end else if (clear) begin
      ramp <= '0;
    end else if (advance) begin
      ramp <= ramp + 1'b1;
    end
  end
`endif

endmodule

// File: rtl/giraffe_adc_emu.sv
// rtl/giraffe_adc_emu.sv - chip-side behavioural emulator of the Giraffe ADC link
//
// Optional build macro: GIRAFFE_EMU_LFSR_EN (LFSR normal-mode data instead of ramp).
//
// Ports:
//   clk            in   single rising-edge clock
//   nrst           in   asynchronous active-low reset
//   adc_rstn       in   chip reset, active-low, sampled synchronously (aborts)
//   adc_ena        in   conversion request, level-sensitive
//   adc_calib_ena  in   calibration mode select, latched at conversion start
//   adc_NOWA       in   calibration word, latched at conversion start
//   adc_ack        out  pulse on the final sub-word of a conversion
//   adc_ack_sub    out  pulse on every sub-word
//   adc_dout       out  sub-word data, held between pulses
//   emu_busy       out  registered "state is not IDLE"
//   emu_conv_cnt   out  saturating count of completed conversions

module giraffe_adc_emu
  import giraffe_pkg::*;
#(
  parameter int NUM_bit   = DEF_NUM_BIT,
  parameter int NUM_STAGE = DEF_NUM_STAGE,
  parameter int CONV_LAT  = DEF_CONV_LAT,
  parameter int SUB_GAP   = DEF_SUB_GAP,
  parameter int FRAME_GAP = DEF_FRAME_GAP
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               adc_rstn,
  input  logic               adc_ena,
  input  logic               adc_calib_ena,
  input  logic [8:0]         adc_NOWA,
  output logic               adc_ack,
  output logic               adc_ack_sub,
  output logic [NUM_bit-1:0] adc_dout,
  output logic               emu_busy,
  output logic [15:0]        emu_conv_cnt
);

  // Timer terminal values: each timed state runs tmr from 0 up to *_LAST.
  localparam logic [7:0] LAT_LAST  = 8'(CONV_LAT - 1);
  localparam logic [7:0] GAP_LAST  = 8'((SUB_GAP > 0) ? SUB_GAP - 1 : 0);
  localparam logic [7:0] REST_LAST = 8'(FRAME_GAP - 1);
  localparam logic [7:0] K_LAST    = 8'(NUM_STAGE - 1);

  emu_state_t         state;
  logic [7:0]         tmr;
  logic [7:0]         k;
  logic               calib_q;
  logic [NUM_bit-1:0] nowa_q;
  logic [NUM_bit-1:0] gen_data;
  logic [NUM_bit-1:0] word;
  logic               gen_advance;
  logic               gen_clear;
  logic               nowa_unused;

  // Only the low NUM_bit calibration bits reach the output.
  assign nowa_unused = ^adc_NOWA;

  assign gen_clear   = !adc_rstn;
  assign gen_advance = adc_rstn && (state == ST_SUB) && !calib_q;
  assign word        = calib_q ? nowa_q : gen_data;

  giraffe_emu_datagen #(
    .NUM_bit (NUM_bit)
  ) u_datagen (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (gen_clear),
    .advance (gen_advance),
    .data    (gen_data)
  );

  // Outputs are registered from the current state, so they trail the state by
  // one cycle: SUB entered after CONV_LAT LAT cycles shows its pulse one later.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      k            <= '0;
      calib_q      <= 1'b0;
      nowa_q       <= '0;
      adc_ack      <= 1'b0;
      adc_ack_sub  <= 1'b0;
      adc_dout     <= '0;
      emu_busy     <= 1'b0;
      emu_conv_cnt <= '0;
    end else if (!adc_rstn) begin
      state        <= ST_IDLE;
      tmr          <= '0;
      k            <= '0;
      calib_q      <= 1'b0;
      nowa_q       <= '0;
      adc_ack      <= 1'b0;
      adc_ack_sub  <= 1'b0;
      adc_dout     <= '0;
      emu_busy     <= 1'b0;
      emu_conv_cnt <= '0;
    end else begin
      adc_ack     <= 1'b0;
      adc_ack_sub <= 1'b0;
      emu_busy    <= (state != ST_IDLE);
      case (state)
        ST_IDLE: begin
          if (adc_ena) begin
            state   <= ST_LAT;
            tmr     <= '0;
            k       <= '0;
            calib_q <= adc_calib_ena;
            nowa_q  <= adc_NOWA[NUM_bit-1:0];
          end
        end
        ST_LAT: begin
          if (tmr == LAT_LAST) begin
            state <= ST_SUB;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        ST_SUB: begin
          adc_ack_sub <= 1'b1;
          adc_dout    <= word;
          tmr         <= '0;
          if (k == K_LAST) begin
            adc_ack <= 1'b1;
            if (emu_conv_cnt != 16'hFFFF) begin
              emu_conv_cnt <= emu_conv_cnt + 16'd1;
            end
            state <= ST_REST;
          end else begin
            k     <= k + 8'd1;
            state <= (SUB_GAP == 0) ? ST_SUB : ST_GAP;
          end
        end
        ST_GAP: begin
          if (tmr == GAP_LAST) begin
            state <= ST_SUB;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        ST_REST: begin
          if (tmr == REST_LAST) begin
            state <= ST_IDLE;
            tmr   <= '0;
          end else begin
            tmr <= tmr + 8'd1;
          end
        end
        default: begin
          state <= ST_IDLE;
          tmr   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_giraffe_adc_emu.sv
// tb/tb_giraffe_adc_emu.sv - self-checking bench for giraffe_adc_emu

module tb_giraffe_adc_emu;

  localparam int NB        = 6;
  localparam int NS        = 2;
  localparam int CL        = 4;
  localparam int SG        = 2;
  localparam int FG        = 3;
  localparam int PERIOD    = CL + NS + (NS - 1) * SG + FG + 1;
  localparam int MASK      = (1 << NB) - 1;

`ifdef GIRAFFE_EMU_LFSR_EN
  localparam logic [NB-1:0] EXP_FIRST  = 6'h30;
  localparam logic [NB-1:0] EXP_SECOND = 6'h38;
`else
  localparam logic [NB-1:0] EXP_FIRST  = 6'h00;
  localparam logic [NB-1:0] EXP_SECOND = 6'h01;
`endif

  logic          clk;
  logic          nrst;
  logic          adc_rstn;
  logic          adc_ena;
  logic          adc_calib_ena;
  logic [8:0]    adc_NOWA;
  logic          adc_ack;
  logic          adc_ack_sub;
  logic [NB-1:0] adc_dout;
  logic          emu_busy;
  logic [15:0]   emu_conv_cnt;

  int passed = 0;
  int total  = 0;

  giraffe_adc_emu #(
    .NUM_bit   (NB),
    .NUM_STAGE (NS),
    .CONV_LAT  (CL),
    .SUB_GAP   (SG),
    .FRAME_GAP (FG)
  ) dut (
    .clk           (clk),
    .nrst          (nrst),
    .adc_rstn      (adc_rstn),
    .adc_ena       (adc_ena),
    .adc_calib_ena (adc_calib_ena),
    .adc_NOWA      (adc_NOWA),
    .adc_ack       (adc_ack),
    .adc_ack_sub   (adc_ack_sub),
    .adc_dout      (adc_dout),
    .emu_busy      (emu_busy),
    .emu_conv_cnt  (emu_conv_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Model: a conversion is described only by its offset n from the sampling
  // edge; pulses fall at n = CL+1 + j*(SG+1), busy covers 1..PERIOD-1.
  logic          m_active;
  int            m_n;
  logic          m_calib;
  logic [8:0]    m_nowa;
  int            m_ramp;
  logic [15:0]   m_lfsr;
  logic [15:0]   m_cnt;
  logic          e_ack;
  logic          e_sub;
  logic [NB-1:0] e_dout;
  logic          e_busy;

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[0] ^ s[2] ^ s[3] ^ s[5], s[15:1]};
  endfunction

  task automatic model_clear();
    m_active = 1'b0;
    m_n      = 0;
    m_ramp   = 0;
    m_lfsr   = 16'hACE1;
    m_cnt    = 16'd0;
    e_ack    = 1'b0;
    e_sub    = 1'b0;
    e_dout   = '0;
    e_busy   = 1'b0;
  endtask

  task automatic model_step();
    int j;
    if (!adc_rstn) begin
      model_clear();
      return;
    end
    e_ack = 1'b0;
    e_sub = 1'b0;
    if (m_active && (m_n + 1 < PERIOD)) begin
      m_n++;
      e_busy = 1'b1;
      if (m_n >= CL + 1 && ((m_n - CL - 1) % (SG + 1)) == 0) begin
        j = (m_n - CL - 1) / (SG + 1);
        if (j < NS) begin
          e_sub = 1'b1;
          if (m_calib) begin
            e_dout = m_nowa[NB-1:0];
          end else begin
`ifdef GIRAFFE_EMU_LFSR_EN
            m_lfsr = lfsr_step(m_lfsr);
            e_dout = m_lfsr[NB-1:0];
`else
            e_dout = NB'(m_ramp & MASK);
            m_ramp++;
`endif
          end
          if (j == NS - 1) begin
            e_ack = 1'b1;
            if (m_cnt != 16'hFFFF) m_cnt++;
          end
        end
      end
    end else begin
      e_busy   = 1'b0;
      m_active = 1'b0;
      if (adc_ena) begin
        m_active = 1'b1;
        m_n      = 0;
        m_calib  = adc_calib_ena;
        m_nowa   = adc_NOWA;
      end
    end
  endtask

  initial model_clear();

  // Inputs only change just after a rising edge, so at the falling edge they
  // are exactly what the next rising edge samples.
  always @(negedge clk) begin
    if (!nrst) model_clear();
    check("m_ack", adc_ack, e_ack);
    check("m_ack_sub", adc_ack_sub, e_sub);
    check("m_dout", adc_dout, e_dout);
    check("m_busy", emu_busy, e_busy);
    check("m_cnt", emu_conv_cnt, m_cnt);
    if (nrst) model_step();
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  int n_ack;
  int last_ack;
  int first_ack;
  logic gap_ok;

  initial begin
    // Reset with arbitrary inputs
    nrst = 1'b0; adc_rstn = 1'b1; adc_ena = 1'b1; adc_calib_ena = 1'b1; adc_NOWA = 9'h1FF;
    step(3);
    @(negedge clk);
    check("t1_rst_busy", emu_busy, 0);
    check("t1_rst_sub", adc_ack_sub, 0);
    check("t1_rst_dout", adc_dout, 0);
    step(1);
    nrst = 1'b1; adc_ena = 1'b0; adc_calib_ena = 1'b0; adc_NOWA = 9'h0;
    step(3);
    @(negedge clk);
    check("t1_idle_busy", emu_busy, 0);
    check("t1_idle_cnt", emu_conv_cnt, 0);

    // Single conversion, ena dropped after the sampling edge
    step(1); adc_ena = 1'b1;
    step(1); adc_ena = 1'b0;
    step(5); @(negedge clk);
    check("t2_c5_sub", adc_ack_sub, 1);
    check("t2_c5_ack", adc_ack, 0);
    check("t2_c5_dout", adc_dout, EXP_FIRST);
    step(3); @(negedge clk);
    check("t2_c8_sub", adc_ack_sub, 1);
    check("t2_c8_ack", adc_ack, 1);
    check("t2_c8_dout", adc_dout, EXP_SECOND);
    check("t2_c8_cnt", emu_conv_cnt, 1);
    step(3); @(negedge clk);
    check("t2_c11_busy", emu_busy, 1);
    step(1); @(negedge clk);
    check("t2_c12_busy", emu_busy, 0);

    // 40 back-to-back conversions from a cleared chip
    step(1); adc_rstn = 1'b0;
    step(1); adc_rstn = 1'b1; adc_ena = 1'b1;
    step(1);
    n_ack = 0; last_ack = -1; first_ack = -1; gap_ok = 1'b1;
    for (int c = 1; c <= 40 * PERIOD; c++) begin
      step(1);
      if (c == 40 * PERIOD - 1) adc_ena = 1'b0;
      @(negedge clk);
      if (adc_ack) begin
        if (last_ack >= 0 && c - last_ack != 12) gap_ok = 1'b0;
        if (first_ack < 0) first_ack = c;
        last_ack = c;
        n_ack++;
      end
    end
    check("t3_n_ack", n_ack, 40);
    check("t3_first_ack", first_ack, 8);
    check("t3_spacing", gap_ok, 1);
    check("t3_cnt", emu_conv_cnt, 40);
`ifndef GIRAFFE_EMU_LFSR_EN
    check("t3_last_dout", adc_dout, 15);
`endif

    // Calibration conversion, then ramp resumes
    step(1); adc_calib_ena = 1'b1; adc_NOWA = 9'h1A5; adc_ena = 1'b1;
    step(1); adc_calib_ena = 1'b0; adc_NOWA = 9'h0; adc_ena = 1'b0;
    step(5); @(negedge clk);
    check("t4_cal_dout0", adc_dout, 6'h25);
    step(3); @(negedge clk);
    check("t4_cal_dout1", adc_dout, 6'h25);
    check("t4_cal_ack", adc_ack, 1);
    step(4); adc_ena = 1'b1;
    step(1); adc_ena = 1'b0;
    step(5); @(negedge clk);
`ifndef GIRAFFE_EMU_LFSR_EN
    check("t4_resume0", adc_dout, 16);
`endif
    step(3); @(negedge clk);
`ifndef GIRAFFE_EMU_LFSR_EN
    check("t4_resume1", adc_dout, 17);
`endif
    check("t4_cnt", emu_conv_cnt, 42);

    // Abort at cycle 6
    step(4); adc_ena = 1'b1;
    step(1); adc_ena = 1'b0;
    step(6); adc_rstn = 1'b0;
    step(1); @(negedge clk);
    check("t5_c7_busy", emu_busy, 0);
    check("t5_c7_dout", adc_dout, 0);
    check("t5_c7_cnt", emu_conv_cnt, 0);
    step(1); adc_rstn = 1'b1;
    @(negedge clk);
    check("t5_c8_ack", adc_ack, 0);
    step(4); adc_ena = 1'b1;
    step(1); adc_ena = 1'b0;
    step(5); @(negedge clk);
    check("t5_next_dout0", adc_dout, EXP_FIRST);
    step(3); @(negedge clk);
    check("t5_next_dout1", adc_dout, EXP_SECOND);
    check("t5_next_cnt", emu_conv_cnt, 1);
    step(5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
